// File: rtl/tinker_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tinker_fetch_pkg
// Shared types and constants for the Tinker instruction fetch stage.
//   INST_W / PC_W      : instruction word and program counter widths
//   RESET_PC_DEFAULT   : Tinker program start address
//   OPC_* / L_*        : instruction field positions
//   OPC_PRIV           : privileged opcode (with L==0 it is the halt word)
//   fetch_state_t      : fetch sequencer states
// -----------------------------------------------------------------------------
package tinker_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h2000;

    // Instruction layout: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], L [11:0]
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int L_MSB   = 11;
    localparam int L_LSB   = 0;

    localparam logic [4:0] OPC_PRIV = 5'h0F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // True for the privileged halt encoding (opcode 0x0F, L == 0).
    function automatic logic is_priv_halt(input logic [INST_W-1:0] word);
        return (word[OPC_MSB:OPC_LSB] == OPC_PRIV) && (word[L_MSB:L_LSB] == '0);
    endfunction

endpackage

// File: rtl/tinker_inst_fifo.sv
// -----------------------------------------------------------------------------
// tinker_inst_fifo
// Synchronous FIFO with first-word-fall-through head, used both as the
// instruction output buffer ({pc, word}) and as the in-flight pc queue.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push_i/data_i  : write an entry (accepted when not full, or full with pop)
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : discard all entries; wins over push and pop
//   head_o         : current head entry (undefined contents when empty)
//   count_o        : number of valid entries, 0..DEPTH
//   empty_o/full_o : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module tinker_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it
    // has been written, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tinker_fetch.sv
// -----------------------------------------------------------------------------
// tinker_fetch
// Instruction fetch stage feeding tinker_core. Holds the PC, issues 32-bit
// word requests, buffers in-order responses with their pc and hands
// {instruction, inst_pc} to the core over valid/ready. Redirects flush the
// buffer and mark every in-flight response as wrong-path.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         request channel (addr always 4-aligned)
//   imem_resp_valid/data              in-order response channel
//   redirect_valid/pc                 PC change from the core (pc[1:0] ignored)
//   inst_valid/ready, instruction,    output instruction handshake; data
//   inst_pc                           reads 0 while inst_valid is low
//   fetch_halted                      only with TINKER_FETCH_HALT_EN
//
// Build option: define TINKER_FETCH_HALT_EN to stop fetching after a
// privileged halt word (opcode 0x0F, L==0) enters the buffer; a redirect
// resumes fetching.
// -----------------------------------------------------------------------------
module tinker_fetch
    import tinker_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] instruction,
    output logic [PC_W-1:0]   inst_pc
`ifdef TINKER_FETCH_HALT_EN
    ,
    output logic              fetch_halted
`endif
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                BUF_W     = PC_W + INST_W;
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] buf_count, outstanding, in_flight_next;
    logic [CNT_W:0]   occupancy;
    logic [BUF_W-1:0] buf_head;
    logic [PC_W-1:0]  pcq_head;
    logic             buf_empty, buf_full, pcq_empty, pcq_full;
    logic             req_fire, resp_fire, buf_push, buf_pop;
`ifdef TINKER_FETCH_HALT_EN
    logic             halt_push;
`endif

    // ---------------------------------------------------------------- request
    // Buffered plus in-flight words never exceed the buffer, so every
    // response is guaranteed a slot.
    assign occupancy      = {1'b0, buf_count} + {1'b0, outstanding};
    assign imem_req_valid = (state_q == RUN) && (occupancy < DEPTH_EXT) && !pcq_full;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // --------------------------------------------------------------- response
    // The pc queue depth is the outstanding count; a response with nothing
    // outstanding is ignored.
    assign resp_fire = imem_resp_valid && !pcq_empty;
    assign buf_pop   = inst_valid && inst_ready && !redirect_valid;
    assign buf_push  = resp_fire && (discard_q == '0) && !redirect_valid &&
                       (!buf_full || buf_pop);

    // Words still owed by memory after this edge; all become wrong-path on a
    // redirect (or halt). Words already marked for discard are part of this
    // count, so it replaces the discard counter rather than adding to it.
    assign in_flight_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);

`ifdef TINKER_FETCH_HALT_EN
    assign halt_push    = buf_push && is_priv_halt(imem_resp_data);
    assign fetch_halted = (state_q == HALTED);
`endif

    // NOTE: every variable assigned here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;

        if (redirect_valid)  pc_d = redirect_pc & ~64'h3;
        else if (req_fire)   pc_d = pc_q + 64'd4;

        if (redirect_valid) begin
            discard_d = in_flight_next;
`ifdef TINKER_FETCH_HALT_EN
        end else if (halt_push) begin
            discard_d = in_flight_next;
`endif
        end else if (resp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
`ifdef TINKER_FETCH_HALT_EN
                if (halt_push) state_d = HALTED;
`endif
            end
`ifdef TINKER_FETCH_HALT_EN
            HALTED: if (redirect_valid) state_d = RUN;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    // ------------------------------------------------------------ pc tracking
    // Every accepted request leaves its pc here; the matching response pops
    // it, whether that response is kept or discarded.
    tinker_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W)
    ) u_pc_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (resp_fire),
        .flush_i (1'b0),
        .head_o  (pcq_head),
        .count_o (outstanding),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    // ------------------------------------------------------- output buffer
    tinker_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUF_W)
    ) u_inst_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (buf_push),
        .data_i  ({pcq_head, imem_resp_data}),
        .pop_i   (buf_pop),
        .flush_i (redirect_valid),
        .head_o  (buf_head),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    assign inst_valid  = !buf_empty;
    assign instruction = buf_empty ? '0 : buf_head[INST_W-1:0];
    assign inst_pc     = buf_empty ? '0 : buf_head[BUF_W-1:INST_W];

endmodule
